// File: rtl/leds_pkg.sv
// Shared constants for the LED chaser: pattern mode encodings and the
// prescaler width helper.
package leds_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  // Counter width able to hold 0..div-1.
  function automatic int prescale_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Speed-scalable prescaler: counts 0..(DIV>>speed)-1 and flags the last count
// as a single-cycle tick. Holds completely while pause is high.
module tick_gen
  import leds_pkg::*;
#(
  parameter int DIV = 5_000_000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       tick
);

  localparam int          CW    = prescale_width(DIV);
  localparam logic [31:0] DIV_W = 32'(DIV);

  logic [CW-1:0] r_count;
  logic [31:0]   w_last;
  logic          w_tick;

  // A ">=" compare lets a sudden speed-up fire on the very next edge instead
  // of wrapping the whole counter range.
  assign w_last = (DIV_W >> speed) - 32'd1;
  assign w_tick = !pause && (32'(r_count) >= w_last);

  // NOTE: sequential state uses non-blocking assignments only; the tick is a
  // pure combinational decode so the pattern register sees it in the same cycle.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else if (!pause) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = w_tick;

endmodule

// File: rtl/led_chaser.sv
// LED pattern generator: rotate-left, rotate-right, bounce and fill-bar,
// stepped by tick_gen; led/step are registered one cycle after each tick.
module led_chaser
  import leds_pkg::*;
#(
  parameter int N_LEDS = 10,
  parameter int DIV    = 5_000_000
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  input  logic              pause,
  output logic [N_LEDS-1:0] led,
  output logic              step
);

  localparam logic [N_LEDS-1:0] LED_FIRST = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_LAST  = LED_FIRST << (N_LEDS - 1);

  if (N_LEDS < 2 || N_LEDS > 32 || DIV < 8) begin : g_param_check
    $error("led_chaser: illegal parameters N_LEDS=%0d DIV=%0d", N_LEDS, DIV);
  end

  logic [N_LEDS-1:0] r_led;
  logic              r_step;
  logic [1:0]        r_mode_q;
  logic              r_dir_up;

  logic              w_tick;
  logic              w_onehot;
  logic [N_LEDS-1:0] w_led_next;
  logic              w_dir_next;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk_50M(clk_50M),
    .reset  (reset),
    .speed  (speed),
    .pause  (pause),
    .tick   (w_tick)
  );

  function automatic logic [N_LEDS-1:0] init_pattern(input logic [1:0] m);
    return (m == MODE_ROT_R) ? LED_LAST : LED_FIRST;
  endfunction

  assign w_onehot = $onehot(r_led);

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    w_led_next = r_led;
    w_dir_next = r_dir_up;
    if (mode != r_mode_q) begin
      w_led_next = init_pattern(mode);
      w_dir_next = 1'b1;
    end else begin
      case (r_mode_q)
        MODE_ROT_L:
          w_led_next = w_onehot ? {r_led[N_LEDS-2:0], r_led[N_LEDS-1]} : LED_FIRST;
        MODE_ROT_R:
          w_led_next = w_onehot ? {r_led[0], r_led[N_LEDS-1:1]} : LED_LAST;
        MODE_BOUNCE: begin
          // Direction flips on the endpoint itself, so endpoints show once.
          if (!w_onehot) begin
            w_led_next = LED_FIRST;
            w_dir_next = 1'b1;
          end else if (r_dir_up) begin
            if (r_led[N_LEDS-1]) begin
              w_dir_next = 1'b0;
              w_led_next = r_led >> 1;
            end else begin
              w_led_next = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_dir_next = 1'b1;
              w_led_next = r_led << 1;
            end else begin
              w_led_next = r_led >> 1;
            end
          end
        end
        default:
          w_led_next = (&r_led) ? '0 : {r_led[N_LEDS-2:0], 1'b1};
      endcase
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_led    <= LED_FIRST;
      r_step   <= 1'b0;
      r_mode_q <= MODE_ROT_L;
      r_dir_up <= 1'b1;
    end else begin
      r_step <= w_tick;
      if (w_tick) begin
        r_led    <= w_led_next;
        r_dir_up <= w_dir_next;
        r_mode_q <= mode;
      end
    end
  end

  assign led  = r_led;
  assign step = r_step;

endmodule

// File: tb/tb_led_chaser.sv
// Scoreboard bench for led_chaser (N_LEDS=4, DIV=8): expected led values and
// step spacings are queued with the stimulus and retired on each step pulse.
module tb_led_chaser;

  localparam int N = 4;
  localparam int D = 8;

  logic       clk_50M = 1'b0;
  logic       reset   = 1'b0;
  logic       pause   = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic [1:0] speed   = 2'b00;
  logic [N-1:0] led;
  logic       step;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] led;
    int           gap;
  } exp_t;

  exp_t exp_q[$];

  led_chaser #(
    .N_LEDS(N),
    .DIV   (D)
  ) dut (
    .clk_50M(clk_50M),
    .reset  (reset),
    .mode   (mode),
    .speed  (speed),
    .pause  (pause),
    .led    (led),
    .step   (step)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic expect_step(input logic [N-1:0] l, input int gap);
    exp_t e;
    e.led = l;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Retire every queued expectation: wait (bounded) for the step pulse, then
  // compare its distance from the previous sample point and the led value.
  task automatic drain(input string tag);
    exp_t e;
    int   n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = 0;
      do begin
        next_cycle();
        n++;
      end while (!step && n < 100);
      check({tag, "_step_seen"}, 32'(step), 32'd1);
      check({tag, "_gap"}, 32'(n), 32'(e.gap));
      check({tag, "_led"}, 32'(led), 32'(e.led));
    end
  endtask

  initial begin
    int steps_seen;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_led", 32'(led), 32'h1);
    check("rst_step", 32'(step), 32'h0);
    next_cycle();
    next_cycle();
    check("rst_hold_led", 32'(led), 32'h1);
    reset = 1'b0;

    // Rotate-left at speed 0.
    expect_step(4'b0010, 8);
    expect_step(4'b0100, 8);
    expect_step(4'b1000, 8);
    expect_step(4'b0001, 8);
    drain("rotl");

    // Bounce: first step loads the initial pattern.
    mode = 2'b10;
    expect_step(4'b0001, 8);
    expect_step(4'b0010, 8);
    expect_step(4'b0100, 8);
    expect_step(4'b1000, 8);
    expect_step(4'b0100, 8);
    expect_step(4'b0010, 8);
    expect_step(4'b0001, 8);
    expect_step(4'b0010, 8);
    drain("bounce");

    // Fill-bar.
    mode = 2'b11;
    expect_step(4'b0001, 8);
    expect_step(4'b0011, 8);
    expect_step(4'b0111, 8);
    expect_step(4'b1111, 8);
    expect_step(4'b0000, 8);
    expect_step(4'b0001, 8);
    drain("fill");

    // Switch to rotate-right three cycles into a step.
    repeat (3) next_cycle();
    mode = 2'b01;
    expect_step(4'b1000, 5);
    expect_step(4'b0100, 8);
    drain("rotr");

    // Speed 0 -> 3 with the counter at 6: immediate tick, then every cycle.
    repeat (6) next_cycle();
    speed = 2'b11;
    expect_step(4'b0010, 1);
    expect_step(4'b0001, 1);
    expect_step(4'b1000, 1);
    expect_step(4'b0100, 1);
    drain("speed");

    // Pause for 20 cycles, then the held tick must come through once.
    pause = 1'b1;
    steps_seen = 0;
    repeat (20) begin
      next_cycle();
      if (step) steps_seen++;
    end
    check("pause_steps", 32'(steps_seen), 32'd0);
    check("pause_led", 32'(led), 32'(4'b0100));
    pause = 1'b0;
    expect_step(4'b0010, 1);
    expect_step(4'b0001, 1);
    expect_step(4'b1000, 1);
    expect_step(4'b0100, 1);
    drain("unpause");

    // Mid-count asynchronous reset between clock edges.
    speed = 2'b00;
    repeat (3) next_cycle();
    check("pre_rst_led", 32'(led), 32'(4'b0100));
    #2;
    reset = 1'b1;
    mode  = 2'b00;
    #1;
    check("async_rst_led", 32'(led), 32'h1);
    check("async_rst_step", 32'(step), 32'h0);
    #3 reset = 1'b0;
    expect_step(4'b0010, 8);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
